// File: rtl/elevator_call_register.sv
// Hall/car call register: sync + debounce each button, latch requests until serviced, summarise vs cur_floor.
// Latency: press to latched request <= 2 + STABLE_SAMPLES*DEBOUNCE_CYCLES + 1 cycles; summary flags +1 cycle.
// Backpressure: none; requests are held until serviced at the floor. Optional CAR_CANCEL_EN: re-press cancels a car target.
module elevator_call_register #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STABLE_SAMPLES  = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] up_btn,
    input  logic [3:0] down_btn,
    input  logic [4:0] car_btn,
    input  logic [4:0] cur_floor,
    input  logic       door_open,
    input  logic       dir_up,
    input  logic       dir_down,
    output logic [3:0] up_req,
    output logic [3:0] down_req,
    output logic [4:0] car_req,
    output logic       any_req,
    output logic       req_above,
    output logic       req_below,
    output logic       req_here
);
    localparam int NB = 13;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // Button vector layout: [12:9] up, [8:5] down, [4:0] car
    logic [NB-1:0]             raw;
    logic [NB-1:0]             sync1, sync2;
    logic [CW-1:0]             cnt;
    logic                      sample_tick;
    logic [STABLE_SAMPLES-1:0] hist     [NB];
    logic [STABLE_SAMPLES-1:0] hist_nxt [NB];
    logic [NB-1:0]             lvl, lvl_nxt;
    logic [NB-1:0]             press;

    assign raw         = {up_btn, down_btn, car_btn};
    assign sample_tick = (cnt == '0);

    // Two-flop synchroniser on every raw button
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce prescaler: 0..DEBOUNCE_CYCLES-1, tick on zero
    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt <= '0;
        else if (cnt == CW'(DEBOUNCE_CYCLES - 1))
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    // Shift history on tick; level moves only when the whole history agrees
    always_comb begin
        lvl_nxt = lvl;
        for (int i = 0; i < NB; i++) begin
            hist_nxt[i] = hist[i];
            if (sample_tick) begin
                hist_nxt[i] = {hist[i][STABLE_SAMPLES-2:0], sync2[i]};
                if (&hist_nxt[i])
                    lvl_nxt[i] = 1'b1;
                else if (~|hist_nxt[i])
                    lvl_nxt[i] = 1'b0;
            end
        end
    end

    // Debounce state and registered one-cycle press pulse on a rising level
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NB; i++)
                hist[i] <= '0;
            lvl   <= '0;
            press <= '0;
        end else begin
            for (int i = 0; i < NB; i++)
                hist[i] <= hist_nxt[i];
            lvl   <= lvl_nxt;
            press <= lvl_nxt & ~lvl;
        end
    end

    // Service decode: only a one-hot floor with the door open clears anything
    logic       floor_ok, idle, svc;
    logic [3:0] clr_up, clr_down;
    logic [4:0] clr_car;

    assign floor_ok = (cur_floor != 5'd0) && ((cur_floor & (cur_floor - 5'd1)) == 5'd0);
    assign idle     = (dir_up == dir_down);   // both set is illegal and treated as idle
    assign svc      = floor_ok && door_open;
    assign clr_car  = svc ? cur_floor : 5'd0;
    assign clr_up   = (svc && (idle || dir_up))   ? cur_floor[4:1] : 4'd0;
    assign clr_down = (svc && (idle || dir_down)) ? cur_floor[3:0] : 4'd0;

    // Request latches; clear wins over a same-cycle press
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            up_req   <= '0;
            down_req <= '0;
            car_req  <= '0;
        end else begin
            up_req   <= (up_req   | press[12:9]) & ~clr_up;
            down_req <= (down_req | press[8:5])  & ~clr_down;
`ifdef CAR_CANCEL_EN
            car_req  <= (car_req  ^ press[4:0])  & ~clr_car;
`else
            car_req  <= (car_req  | press[4:0])  & ~clr_car;
`endif
        end
    end

    // Map all vectors onto floors (bit4 = floor1 .. bit0 = floor5); higher floor = lower bit
    logic [4:0] floors, mask_above, mask_below;

    assign floors     = {up_req, 1'b0} | {1'b0, down_req} | car_req;
    assign mask_above = cur_floor - 5'd1;
    assign mask_below = ~(cur_floor | mask_above);

    // Registered summary flags, forced low for an invalid floor
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            any_req   <= 1'b0;
            req_above <= 1'b0;
            req_below <= 1'b0;
            req_here  <= 1'b0;
        end else begin
            any_req   <= |floors;
            req_above <= floor_ok && |(floors & mask_above);
            req_below <= floor_ok && |(floors & mask_below);
            req_here  <= floor_ok && |(floors & cur_floor);
        end
    end
endmodule

// File: tb/tb_elevator_call_register.sv
// Directed bench for elevator_call_register with DEBOUNCE_CYCLES=4, STABLE_SAMPLES=3.
// Every step samples outputs 1 time unit after the rising edge and drives new inputs there.
// Build with +define+CAR_CANCEL_EN to exercise the car-target cancel behaviour.
module tb_elevator_call_register;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] up_btn, down_btn;
    logic [4:0] car_btn, cur_floor;
    logic       door_open, dir_up, dir_down;
    logic [3:0] up_req, down_req;
    logic [4:0] car_req;
    logic       any_req, req_above, req_below, req_here;

    int total = 0;
    int bad   = 0;
    logic seen;

    always #5 clk = ~clk;

    elevator_call_register #(.DEBOUNCE_CYCLES(4), .STABLE_SAMPLES(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .up_btn(up_btn), .down_btn(down_btn), .car_btn(car_btn),
        .cur_floor(cur_floor), .door_open(door_open), .dir_up(dir_up), .dir_down(dir_down),
        .up_req(up_req), .down_req(down_req), .car_req(car_req),
        .any_req(any_req), .req_above(req_above), .req_below(req_below), .req_here(req_here)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Drop every button and let the debounced levels fall back to 0
    task automatic release_all();
        up_btn = 4'd0; down_btn = 4'd0; car_btn = 5'd0;
        run(18);
    endtask

    // Visit each floor with the door open and the car idle: clears everything
    task automatic service_all();
        door_open = 1'b1; dir_up = 1'b0; dir_down = 1'b0;
        for (int f = 0; f < 5; f++) begin
            cur_floor = 5'b00001 << f;
            step();
        end
        door_open = 1'b0; cur_floor = 5'd0;
        step();
    endtask

    initial begin
        // Reset with every button held
        reset_n = 1'b0; up_btn = 4'hF; down_btn = 4'hF; car_btn = 5'h1F;
        cur_floor = 5'd0; door_open = 1'b0; dir_up = 1'b0; dir_down = 1'b0;
        run(10);
        chk("rst_up",    8'(up_req),   8'h0);
        chk("rst_down",  8'(down_req), 8'h0);
        chk("rst_car",   8'(car_req),  8'h0);
        chk("rst_any",   8'(any_req),  8'h0);
        chk("rst_flags", 8'({req_above, req_below, req_here}), 8'h0);

        // Nothing may latch within 2 + 3*4 cycles of release
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 13; i++) begin
            step();
            if (any_req) seen = 1'b1;
        end
        chk("no_early_req", 8'(seen), 8'h0);
        run(5);
        chk("held_up",   8'(up_req),   8'hF);
        chk("held_down", 8'(down_req), 8'hF);
        chk("held_car",  8'(car_req),  8'h1F);
        chk("invalid_floor_flags", 8'({req_above, req_below, req_here}), 8'h0);
        release_all();
        service_all();
        step();
        chk("all_served", 8'(any_req), 8'h0);

        // Bounce on u2: level flips every 4 cycles so consecutive samples always disagree
        seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            up_btn = ((i / 4) % 2 == 1) ? 4'b0100 : 4'b0000;
            step();
            if (any_req) seen = 1'b1;
        end
        chk("bounce_quiet", 8'(seen), 8'h0);
        up_btn = 4'b0100;
        run(18);
        chk("bounce_up",   8'(up_req),   8'h04);
        chk("bounce_any",  8'(any_req),  8'h1);
        chk("bounce_down", 8'(down_req), 8'h0);
        chk("bounce_car",  8'(car_req),  8'h0);
        release_all();
        service_all();

        // Directional clear at floor 3 while heading up
        up_btn = 4'b0010; down_btn = 4'b0100;
        run(18);
        chk("dir_pre_up",   8'(up_req),   8'h02);
        chk("dir_pre_down", 8'(down_req), 8'h04);
        release_all();
        cur_floor = 5'b00100; dir_up = 1'b1; door_open = 1'b1;
        step();
        chk("dir_up_cleared",  8'(up_req),   8'h0);
        chk("dir_down_kept",   8'(down_req), 8'h04);
        step();
        chk("dir_here", 8'({req_above, req_below, req_here}), 8'b001);
        door_open = 1'b0; dir_up = 1'b0;
        service_all();

        // Summaries: target5 and u1 pending
        car_btn = 5'b00001; up_btn = 4'b1000;
        run(18);
        chk("sum_car", 8'(car_req), 8'h01);
        chk("sum_up",  8'(up_req),  8'h08);
        cur_floor = 5'b01000;
        step();
        chk("sum_floor2", 8'({req_above, req_below, req_here}), 8'b110);
        cur_floor = 5'b00001;
        step();
        chk("sum_floor5", 8'({req_above, req_below, req_here}), 8'b011);
        release_all();
        service_all();

        // Collision: target1 pressed while its floor is being serviced
        cur_floor = 5'b10000; door_open = 1'b1;
        car_btn = 5'b10000;
        seen = 1'b0;
        for (int i = 0; i < 18; i++) begin
            step();
            if (car_req[4]) seen = 1'b1;
        end
        chk("coll_served", 8'(seen), 8'h0);
        car_btn = 5'd0;
        run(18);
        // Multi-hot floor with door open: no clears, flags forced low
        cur_floor = 5'b11000;
        car_btn = 5'b01000;
        run(18);
        chk("multi_car",   8'(car_req), 8'h08);
        chk("multi_flags", 8'({req_above, req_below, req_here}), 8'h0);
        chk("multi_any",   8'(any_req), 8'h1);
        release_all();
        service_all();

        // Second press of target3 after a release
        car_btn = 5'b00100;
        run(18);
        chk("cancel_first", 8'(car_req), 8'h04);
        car_btn = 5'd0;
        run(18);
        car_btn = 5'b00100;
        run(18);
`ifdef CAR_CANCEL_EN
        chk("cancel_second", 8'(car_req), 8'h00);
`else
        chk("cancel_second", 8'(car_req), 8'h04);
`endif
        release_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
